// File: rtl/mio_pkg.sv
// Shared MIO types: arbiter state encoding, bus-owner encoding and address
// region codes (address bits [31:28]).
// No ports; imported by the arbiter and its interface users.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam logic [3:0] REGION_RAM   = 4'h0;
  localparam logic [3:0] REGION_BUF   = 4'hC;
  localparam logic [3:0] REGION_VRAM  = 4'hD;
  localparam logic [3:0] REGION_GPIO0 = 4'hE;
  localparam logic [3:0] REGION_GPIO1 = 4'hF;

endpackage

// File: rtl/mio_arbiter_if.sv
// Bundle of the CPU port, DMA port and MIO bus-side signals of mio_arbiter.
// Ports: none; modport slave is the arbiter view, modport master is the
// environment view (both masters plus the bus decoder returning read data).
interface mio_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_last;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic [31:0] addr_bus;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    output dma_ack, dma_rdata, dma_rvalid,
    output addr_bus, bus_wdata, bus_we, owner,
    input  bus_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    input  dma_ack, dma_rdata, dma_rvalid,
    input  addr_bus, bus_wdata, bus_we, owner,
    output bus_rdata
  );

endinterface

// File: rtl/mio_arbiter.sv
// Two-master (CPU, DMA) arbiter sharing the single MIO bus port.
// Latency: ack same cycle as request, bus driven next cycle, read data
// registered two cycles after that. Backpressure: a master holds req and
// payload until its ack; acks only appear while the bus is free.
// Ports: clk, rst_n (async active-low), io (mio_arbiter_if.slave).
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int STARVE_LIM = 8,
  parameter int MAX_BURST  = 16
) (
  input logic         clk,
  input logic         rst_n,
  mio_arbiter_if.slave io
);

  localparam int WAIT_W  = $clog2(STARVE_LIM + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               owner_q, owner_d;
  logic [WAIT_W-1:0]  dma_wait_q, dma_wait_d;
  logic               dma_lock_q, dma_lock_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic [31:0]        dma_rdata_q, dma_rdata_d;
  logic               cpu_rvalid_q, cpu_rvalid_d;
  logic               dma_rvalid_q, dma_rvalid_d;

  logic               bus_free;
  logic               starved;
  logic               dma_win;
  logic               cpu_ack_c;
  logic               dma_ack_c;
  logic [BURST_W-1:0] burst_nxt;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    owner_d      = owner_q;
    dma_wait_d   = dma_wait_q;
    dma_lock_d   = dma_lock_q;
    burst_cnt_d  = burst_cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    cpu_ack_c    = 1'b0;
    dma_ack_c    = 1'b0;
    burst_nxt    = burst_cnt_q + BURST_W'(1);

    // A read in XFER occupies the bus for its RAM latency cycle; a write
    // or the latency cycle itself can overlap the next grant.
    bus_free = (state_q == IDLE) || (state_q == RD_WAIT) ||
               ((state_q == XFER) && we_q);
    starved  = dma_wait_q >= WAIT_W'(STARVE_LIM);
    // DMA wins when locked in a burst, starved, or uncontested.
    dma_win  = io.dma_req && (dma_lock_q || starved || !io.cpu_req);

    if (bus_free) begin
      dma_ack_c = dma_win;
      cpu_ack_c = io.cpu_req && !dma_win;
    end

    if (!bus_free) begin
      state_d = RD_WAIT;
    end else if (cpu_ack_c || dma_ack_c) begin
      state_d = XFER;
    end else begin
      state_d = IDLE;
    end

    if (dma_ack_c) begin
      addr_d  = io.dma_addr;
      wdata_d = io.dma_wdata;
      we_d    = io.dma_we;
      owner_d = OWN_DMA;
    end else if (cpu_ack_c) begin
      addr_d  = io.cpu_addr;
      wdata_d = io.cpu_wdata;
      we_d    = io.cpu_we;
      owner_d = OWN_CPU;
    end

    // owner_q still names the read's master here: a grant taken in this
    // same cycle only updates owner_q at the closing edge.
    if (state_q == RD_WAIT) begin
      if (owner_q == OWN_DMA) begin
        dma_rdata_d  = io.bus_rdata;
        dma_rvalid_d = 1'b1;
      end else begin
        cpu_rdata_d  = io.bus_rdata;
        cpu_rvalid_d = 1'b1;
      end
    end

    if (dma_ack_c) begin
      dma_wait_d = '0;
    end else if (io.dma_req && (dma_wait_q != WAIT_W'(STARVE_LIM))) begin
      dma_wait_d = dma_wait_q + WAIT_W'(1);
    end

    // The beat that opens a burst is counted, so MAX_BURST acks in total
    // end the lock and let a waiting CPU in.
    if (dma_ack_c) begin
      if (io.dma_last || (burst_nxt == BURST_W'(MAX_BURST))) begin
        dma_lock_d  = 1'b0;
        burst_cnt_d = '0;
      end else begin
        dma_lock_d  = 1'b1;
        burst_cnt_d = burst_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      owner_q      <= OWN_CPU;
      dma_wait_q   <= '0;
      dma_lock_q   <= 1'b0;
      burst_cnt_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      dma_wait_q   <= dma_wait_d;
      dma_lock_q   <= dma_lock_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign io.cpu_ack    = cpu_ack_c;
  assign io.dma_ack    = dma_ack_c;
  assign io.cpu_rdata  = cpu_rdata_q;
  assign io.dma_rdata  = dma_rdata_q;
  assign io.cpu_rvalid = cpu_rvalid_q;
  assign io.dma_rvalid = dma_rvalid_q;
  // Bus outputs decode straight from registered state so an async reset
  // removes the strobe and address without waiting for a clock.
  assign io.addr_bus   = (state_q == IDLE) ? '0 : addr_q;
  assign io.bus_wdata  = (state_q == IDLE) ? '0 : wdata_q;
  assign io.bus_we     = (state_q == XFER) && we_q;
  assign io.owner      = owner_q;

endmodule

// File: tb/tb_mio_arbiter.sv
// Self-checking bench for mio_arbiter: vector table plus multi-cycle
// sequences (starvation, burst limit, reset mid-transfer, overlap).
module tb_mio_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mio_arbiter_if bus_if ();

  mio_arbiter #(.STARVE_LIM(8), .MAX_BURST(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus_if)
  );

  // Synchronous RAM model: one-cycle read latency on addr_bus.
  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) bus_if.bus_rdata <= ram_fn(bus_if.addr_bus);

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic        e_cack, e_dack, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_own, e_crv, e_drv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.cpu_req   = 1'b0;
    bus_if.cpu_we    = 1'b0;
    bus_if.cpu_addr  = '0;
    bus_if.cpu_wdata = '0;
    bus_if.dma_req   = 1'b0;
    bus_if.dma_we    = 1'b0;
    bus_if.dma_addr  = '0;
    bus_if.dma_wdata = '0;
    bus_if.dma_last  = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},   bus_if.addr_bus,   32'h0);
    chk({tag, "_wdata"},  bus_if.bus_wdata,  32'h0);
    chk({tag, "_we"},     bus_if.bus_we,     32'h0);
    chk({tag, "_acks"},   {bus_if.cpu_ack, bus_if.dma_ack}, 32'h0);
    chk({tag, "_rvalid"}, {bus_if.cpu_rvalid, bus_if.dma_rvalid}, 32'h0);
    chk({tag, "_crdata"}, bus_if.cpu_rdata,  32'h0);
    chk({tag, "_drdata"}, bus_if.dma_rdata,  32'h0);
    chk({tag, "_owner"},  bus_if.owner,      32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int b;
    logic cpu_done;
    logic [1:0] exp_ack;

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hD000_0040, 32'h0BAD_F00D,
                1'b0, 1'b1, 1'b1, 32'hD000_0040, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b1, 1'b1, 32'hC000_0008, 32'h2222_2222,
                1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hD000_0100, 32'h0,
                1'b0, 1'b1, 1'b0, 32'hD000_0100, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0100_FEFF};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1, 1'b0, 32'hC000_0000, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0044_FFBB};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Vector table: single transaction from IDLE, observed T..T+4
    for (int i = 0; i < 7; i++) begin
      bus_if.cpu_req   = vecs[i].c_req;
      bus_if.cpu_we    = vecs[i].c_we;
      bus_if.cpu_addr  = vecs[i].c_addr;
      bus_if.cpu_wdata = vecs[i].c_wdata;
      bus_if.dma_req   = vecs[i].d_req;
      bus_if.dma_we    = vecs[i].d_we;
      bus_if.dma_addr  = vecs[i].d_addr;
      bus_if.dma_wdata = vecs[i].d_wdata;
      #1;
      chk($sformatf("v%0d_cpu_ack", i), bus_if.cpu_ack, vecs[i].e_cack);
      chk($sformatf("v%0d_dma_ack", i), bus_if.dma_ack, vecs[i].e_dack);
      chk($sformatf("v%0d_we_T", i), bus_if.bus_we, 1'b0);
      step();
      idle_inputs();
      #1;
      chk($sformatf("v%0d_we", i), bus_if.bus_we, vecs[i].e_we);
      chk($sformatf("v%0d_addr", i), bus_if.addr_bus, vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), bus_if.bus_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_owner", i), bus_if.owner, vecs[i].e_own);
      step();
      chk($sformatf("v%0d_we_T2", i), bus_if.bus_we, 1'b0);
      step();
      #1;
      chk($sformatf("v%0d_crv", i), bus_if.cpu_rvalid, vecs[i].e_crv);
      chk($sformatf("v%0d_drv", i), bus_if.dma_rvalid, vecs[i].e_drv);
      if (vecs[i].e_crv) chk($sformatf("v%0d_crdata", i), bus_if.cpu_rdata, vecs[i].e_rdata);
      if (vecs[i].e_drv) chk($sformatf("v%0d_drdata", i), bus_if.dma_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_idle_addr", i), bus_if.addr_bus, 32'h0);
      step();
      chk($sformatf("v%0d_rv_off", i), {bus_if.cpu_rvalid, bus_if.dma_rvalid}, 2'b00);
    end

    // Starvation: both write continuously, CPU wins 8, DMA the 9th
    do_reset();
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 32'h100;
    bus_if.dma_req = 1'b1; bus_if.dma_we = 1'b1; bus_if.dma_addr = 32'hC000_0100;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      #1;
      exp_ack = (cyc == 9) ? 2'b01 : 2'b10;
      chk($sformatf("starve_c%0d", cyc), {bus_if.cpu_ack, bus_if.dma_ack}, exp_ack);
      if (cyc == 10) chk("starve_owner", bus_if.owner, 1'b1);
      step();
    end
    idle_inputs();

    // Burst limit: 20-beat DMA burst with CPU pending from cycle 2
    do_reset();
    b = 0;
    cpu_done = 1'b0;
    bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 32'h200; bus_if.cpu_wdata = 32'hCAFE_0000;
    bus_if.dma_we = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      bus_if.dma_req   = (b < 20) || (cyc == 22);
      bus_if.dma_last  = (b == 19) || (cyc == 22);
      bus_if.dma_addr  = 32'hD000_0000 + 32'(b * 4);
      bus_if.dma_wdata = 32'(b);
      bus_if.cpu_req   = ((cyc >= 2) && !cpu_done) || (cyc == 22);
      #1;
      exp_ack = (cyc <= 16) ? 2'b01 : (cyc == 17) ? 2'b10 : (cyc <= 21) ? 2'b01 : 2'b10;
      chk($sformatf("burst_c%0d", cyc), {bus_if.cpu_ack, bus_if.dma_ack}, exp_ack);
      if (bus_if.dma_ack) b++;
      if (bus_if.cpu_ack) cpu_done = 1'b1;
      step();
    end
    idle_inputs();
    chk("burst_beats", b, 20);

    // Reset during RD_WAIT of a DMA read
    do_reset();
    bus_if.dma_req = 1'b1; bus_if.dma_addr = 32'hD000_0100;
    #1;
    step();
    idle_inputs();
    repeat (3) step();
    chk("rst_pre_drdata", bus_if.dma_rdata, 32'h0100_FEFF);
    chk("rst_pre_owner", bus_if.owner, 1'b1);
    bus_if.dma_req = 1'b1; bus_if.dma_addr = 32'hD000_0200;
    #1;
    step();
    idle_inputs();
    step();
    chk("rst_rdwait_addr", bus_if.addr_bus, 32'hD000_0200);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rst_no_rv%0d", k), {bus_if.cpu_rvalid, bus_if.dma_rvalid}, 2'b00);
    end
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b1;
    bus_if.cpu_addr = 32'h14; bus_if.cpu_wdata = 32'hA5A5_A5A5;
    #1;
    chk("rst_post_ack", bus_if.cpu_ack, 1'b1);
    step();
    idle_inputs();
    chk("rst_post_we", bus_if.bus_we, 1'b1);
    chk("rst_post_addr", bus_if.addr_bus, 32'h14);
    rst_n = 1'b0;
    #1;
    chk("rst_xfer_we", bus_if.bus_we, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // CPU read overlapped by DMA write in RD_WAIT, then another CPU read
    bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 32'h10;
    #1;
    chk("alt_T_cack", bus_if.cpu_ack, 1'b1);
    step();
    bus_if.cpu_req = 1'b0;
    bus_if.dma_req = 1'b1; bus_if.dma_we = 1'b1;
    bus_if.dma_addr = 32'hC000_0010; bus_if.dma_wdata = 32'h5555_AAAA;
    #1;
    chk("alt_T1_dack", bus_if.dma_ack, 1'b0);
    chk("alt_T1_owner", bus_if.owner, 1'b0);
    step();
    chk("alt_T2_dack", bus_if.dma_ack, 1'b1);
    chk("alt_T2_addr", bus_if.addr_bus, 32'h10);
    step();
    bus_if.dma_req = 1'b0;
    bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 32'h44;
    #1;
    chk("alt_T3_we", bus_if.bus_we, 1'b1);
    chk("alt_T3_addr", bus_if.addr_bus, 32'hC000_0010);
    chk("alt_T3_wdata", bus_if.bus_wdata, 32'h5555_AAAA);
    chk("alt_T3_owner", bus_if.owner, 1'b1);
    chk("alt_T3_rv", {bus_if.cpu_rvalid, bus_if.dma_rvalid}, 2'b10);
    chk("alt_T3_crdata", bus_if.cpu_rdata, 32'h1234_5678);
    chk("alt_T3_cack", bus_if.cpu_ack, 1'b1);
    step();
    bus_if.cpu_req = 1'b0;
    bus_if.dma_req = 1'b1; bus_if.dma_addr = 32'hC000_0014; bus_if.dma_wdata = 32'h6666_0000;
    #1;
    chk("alt_T4_owner", bus_if.owner, 1'b0);
    chk("alt_T4_addr", bus_if.addr_bus, 32'h44);
    chk("alt_T4_rv", {bus_if.cpu_rvalid, bus_if.dma_rvalid}, 2'b00);
    chk("alt_T4_crdata", bus_if.cpu_rdata, 32'h1234_5678);
    chk("alt_T4_dack", bus_if.dma_ack, 1'b0);
    step();
    chk("alt_T5_dack", bus_if.dma_ack, 1'b1);
    step();
    idle_inputs();
    #1;
    chk("alt_T6_rv", {bus_if.cpu_rvalid, bus_if.dma_rvalid}, 2'b10);
    chk("alt_T6_crdata", bus_if.cpu_rdata, 32'h0044_FFBB);
    chk("alt_T6_owner", bus_if.owner, 1'b1);
    chk("alt_T6_addr", bus_if.addr_bus, 32'hC000_0014);
    step();
    chk("alt_T7_rv", {bus_if.cpu_rvalid, bus_if.dma_rvalid}, 2'b00);
    chk("alt_T7_drdata", bus_if.dma_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Two-master arbiter placed in front of the MIO bus decoder. It shares the single CPU-side bus port (address, write data, write strobe, read data) between the CPU and a DMA/blit engine that copies between data RAM, the video buffer (0xC…) and VRAM (0xD…). The arbiter registers each accepted request, sequences the one-cycle synchronous-RAM read latency, and returns read data to the owning master. Fairness comes from CPU priority plus a DMA starvation limit and bounded DMA bursts.

## Interface
Parameters:
- STARVE_LIM, 8: cycles a pending DMA request may lose before it is forced to win.
- MAX_BURST, 16: maximum consecutive DMA beats under burst lock.

Ports (reset is asynchronous, active-low; one clock):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU request; hold it with its payload until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_ack  out  1  combinational accept, same cycle as the grant
- cpu_rdata  out  32  registered read data
- cpu_rvalid  out  1  one-cycle read-data strobe
- dma_req, dma_we, dma_addr[31:0], dma_wdata[31:0]  in  DMA equivalents of the CPU inputs
- dma_last  in  1  marks the final beat of a DMA burst
- dma_ack, dma_rdata[31:0], dma_rvalid  out  DMA equivalents of the CPU outputs
- addr_bus  out  32  to MIO bus address
- bus_wdata  out  32  to MIO bus write data
- bus_we  out  1  to MIO bus mem_w
- bus_rdata  in  32  from MIO bus read data
- owner  out  1  0 = CPU, 1 = DMA (the master of the current or last transfer)

## Operation
- FSM states: IDLE, XFER, RD_WAIT.
  - XFER drives the registered addr/wdata/we onto the bus.
  - RD_WAIT holds the address for the RAM latency cycle.
- Bus is "free" in: IDLE; XFER with we = 1; RD_WAIT. Acks are issued only when the bus is free.
- On an ack, the arbiter captures addr, wdata, we and owner at the clock edge, then enters XFER.
- Free with no request: XFER or RD_WAIT return to IDLE.
- Winner selection, first matching rule applies:
  1. dma_lock and dma_req.
  2. dma_wait ≥ STARVE_LIM and dma_req.
  3. cpu_req.
  4. dma_req.
- dma_wait:
  - increments, saturating, in each cycle that dma_req = 1 and dma_ack = 0.
  - clears on dma_ack.
- dma_lock:
  - set on dma_ack with dma_last = 0.
  - cleared on dma_ack with dma_last = 1, or when burst_cnt reaches MAX_BURST.
- burst_cnt counts DMA acks while locked and clears when the lock clears. After a MAX_BURST clear, a pending cpu_req wins the next grant.
- Writes: bus_we = 1 for exactly the one XFER cycle.
- Reads: bus_rdata is captured at the end of RD_WAIT into the owner's rdata; that owner's rvalid pulses in the next cycle.
- Outputs in IDLE and in RD_WAIT: bus_we = 0. In IDLE, addr_bus and bus_wdata are 0.
- Arbiter does not decode addresses; every address is forwarded unmodified.

## Timing
- Request present in cycle T with the bus free:
  - ack in cycle T.
  - bus driven in cycle T+1.
  - read data captured at the end of T+2.
  - rvalid in T+3.
- Throughput: one write per cycle back-to-back; one read per two cycles.
- Simultaneous requests: exactly one ack per cycle, following the rules above. The loser's payload must stay stable.
- rdata holds its value between rvalids. rvalid never overlaps between masters.
- A master may raise a new req in the cycle after its ack, and may be accepted while its earlier read is still in RD_WAIT.
- Reset values (async on rst_n low): state IDLE; all acks, rvalids and bus_we 0; addr_bus, bus_wdata, rdata 0; owner 0; dma_wait, burst_cnt, dma_lock 0.
- Reset during XFER or RD_WAIT aborts the transfer: no rvalid is issued, and the write strobe drops immediately.

## Structure
- Shared package mio_pkg holds:
  - state enum {IDLE, XFER, RD_WAIT}.
  - owner encoding OWN_CPU = 0, OWN_DMA = 1.
  - region constants 0x0 RAM, 0xC buffer, 0xD VRAM, 0xE/0xF GPIO.
- No sub-module. Winner selection, counters and FSM live in one module.

## Test plan
- CPU write 0x0000_0010 ← 0xDEAD_BEEF, DMA idle -> cpu_ack at T, bus_we = 1 and addr_bus = 0x10 at T+1 only, then IDLE.
- CPU read 0x0000_0010 with RAM model returning 0x1234_5678 -> cpu_rvalid at T+3 with cpu_rdata = 0x1234_5678; dma_rvalid stays 0.
- cpu_req and dma_req held high continuously (both writes) -> CPU wins 8 consecutive cycles, the DMA is acked on the 9th, dma_wait clears.
- DMA burst of 20 beats (dma_last only on beat 20) with cpu_req pending -> 16 DMA acks, then 1 CPU ack, then DMA resumes as unlocked (CPU priority applies).
- rst_n low mid-read in RD_WAIT -> all outputs 0 asynchronously, no rvalid after release, first post-reset request acked normally.
- Alternating CPU read/DMA write back-to-back -> DMA write accepted in RD_WAIT cycle, CPU rdata unaffected, owner tracks each issue.
